// File: rtl/dct_pkg.sv
// Shared definitions for the 8x8 2D DCT sequencer: state encoding, block geometry
// and the row-major word index used by the transpose and the bench.
package dct_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ROW  = 2'd1,
    COL  = 2'd2,
    DONE = 2'd3
  } dct_state_t;

  localparam int BLOCK_WORDS = 64;
  localparam int ROW_WORDS   = 8;

  function automatic int idx(input int row, input int col);
    return row * ROW_WORDS + col;
  endfunction

endpackage

// File: rtl/dct_2d_ctrl_transpose.sv
// Combinational 8x8 transpose of a row-major block: output word (j,i) = input word (i,j).
module dct_transpose_8x8
  import dct_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [BLOCK_WORDS*DATA_WIDTH-1:0] in_blk,
  output logic [BLOCK_WORDS*DATA_WIDTH-1:0] out_blk
);

  for (genvar i = 0; i < ROW_WORDS; i++) begin : g_row
    for (genvar j = 0; j < ROW_WORDS; j++) begin : g_col
      assign out_blk[idx(j, i)*DATA_WIDTH +: DATA_WIDTH] =
        in_blk[idx(i, j)*DATA_WIDTH +: DATA_WIDTH];
    end
  end

endmodule

// File: rtl/dct_2d_ctrl.sv
// Two-pass 8x8 2D DCT sequencer: row pass, transpose, column pass on one shared
// external 1D datapath, then holds the row-major result until the consumer takes it.
module dct_2d_ctrl
  import dct_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int DCT_LATENCY = 2
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [BLOCK_WORDS*DATA_WIDTH-1:0] in_data,
  input  logic [BLOCK_WORDS*DATA_WIDTH-1:0] in_coeff,
  output logic [BLOCK_WORDS*DATA_WIDTH-1:0] dct_data_in,
  output logic [BLOCK_WORDS*DATA_WIDTH-1:0] dct_coeff,
  input  logic [BLOCK_WORDS*DATA_WIDTH-1:0] dct_out,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [BLOCK_WORDS*DATA_WIDTH-1:0] out_data,
  output logic                              busy,
  output logic                              dct_pass,
  output dct_state_t                        dbg_state
);

  localparam int         BW  = BLOCK_WORDS * DATA_WIDTH;
  localparam logic [3:0] LAT = 4'(DCT_LATENCY);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both
  // high; a source holds valid and data stable until then, and ready never waits on valid.

  dct_state_t    state, state_nxt;
  logic [3:0]    cnt;
  logic          pass_done;
  logic [BW-1:0] dct_out_t;

  assign pass_done = (cnt == LAT);
  assign dbg_state = state;

  // One transpose serves both capture points: row results into the column
  // operand, and column results back into row-major order.
  dct_transpose_8x8 #(.DATA_WIDTH(DATA_WIDTH)) u_transpose (
    .in_blk  (dct_out),
    .out_blk (dct_out_t)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_nxt = ROW;
      end
      ROW:  if (pass_done) state_nxt = COL;
      COL:  if (pass_done) state_nxt = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operands stay frozen during each pass so the shared datapath sees a stable input.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt         <= '0;
      dct_data_in <= '0;
      dct_coeff   <= '0;
      out_data    <= '0;
      dct_pass    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            dct_data_in <= in_data;
            dct_coeff   <= in_coeff;
            cnt         <= '0;
          end
        end
        ROW: begin
          if (pass_done) begin
            dct_data_in <= dct_out_t;
            cnt         <= '0;
            dct_pass    <= 1'b1;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        COL: begin
          if (pass_done) begin
            out_data <= dct_out_t;
            cnt      <= '0;
            dct_pass <= 1'b0;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dct_2d_ctrl.sv
// Directed bench for dct_2d_ctrl: one controller with a 2-cycle datapath model and
// one with a combinational model, checked against hand-derived blocks and cycle counts.
module tb_dct_2d_ctrl;
  import dct_pkg::*;

  localparam int W  = 32;
  localparam int BW = 64 * W;
  typedef logic [BW-1:0] blk_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;
  int mode  = 0;  // 0 identity, 1 reverse columns within each row, 2 add one

  logic exp_q_unused;
  logic [BW-1:0] exp_q[$];

  // ---------------- DUT A: DCT_LATENCY = 2 ----------------
  logic in_valid_a, in_ready_a, out_valid_a, out_ready_a, busy_a, dct_pass_a;
  blk_t in_data_a, in_coeff_a, dct_data_in_a, dct_coeff_a, dct_out_a, out_data_a;
  dct_state_t st_a;

  dct_2d_ctrl #(.DATA_WIDTH(W), .DCT_LATENCY(2)) dut_a (
    .clk(clk), .reset(reset), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .in_data(in_data_a), .in_coeff(in_coeff_a), .dct_data_in(dct_data_in_a),
    .dct_coeff(dct_coeff_a), .dct_out(dct_out_a), .out_valid(out_valid_a),
    .out_ready(out_ready_a), .out_data(out_data_a), .busy(busy_a),
    .dct_pass(dct_pass_a), .dbg_state(st_a)
  );

  // ---------------- DUT B: DCT_LATENCY = 0 ----------------
  logic in_valid_b, in_ready_b, out_valid_b, out_ready_b, busy_b, dct_pass_b;
  blk_t in_data_b, in_coeff_b, dct_data_in_b, dct_coeff_b, dct_out_b, out_data_b;
  dct_state_t st_b;

  dct_2d_ctrl #(.DATA_WIDTH(W), .DCT_LATENCY(0)) dut_b (
    .clk(clk), .reset(reset), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .in_data(in_data_b), .in_coeff(in_coeff_b), .dct_data_in(dct_data_in_b),
    .dct_coeff(dct_coeff_b), .dct_out(dct_out_b), .out_valid(out_valid_b),
    .out_ready(out_ready_b), .out_data(out_data_b), .busy(busy_b),
    .dct_pass(dct_pass_b), .dbg_state(st_b)
  );

  // ---------------- 1D datapath models ----------------
  function automatic blk_t model_f(input int m, input blk_t x);
    blk_t y;
    y = '0;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        case (m)
          1:       y[(r*8+c)*W +: W] = x[(r*8+7-c)*W +: W];
          2:       y[(r*8+c)*W +: W] = x[(r*8+c)*W +: W] + W'(1);
          default: y[(r*8+c)*W +: W] = x[(r*8+c)*W +: W];
        endcase
    return y;
  endfunction

  blk_t p1, p2;
  always @(posedge clk) begin
    p1 <= model_f(mode, dct_data_in_a);
    p2 <= p1;
  end
  assign dct_out_a = p2;
  assign dct_out_b = model_f(mode, dct_data_in_b);

  // ---------------- block builders ----------------
  function automatic blk_t ramp();
    blk_t y;
    for (int k = 0; k < 64; k++) y[k*W +: W] = W'(k);
    return y;
  endfunction

  function automatic blk_t fill(input logic [W-1:0] v);
    blk_t y;
    for (int k = 0; k < 64; k++) y[k*W +: W] = v;
    return y;
  endfunction

  function automatic blk_t rev_exp();
    blk_t y;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++) y[(i*8+j)*W +: W] = W'((7-i)*8 + (7-j));
    return y;
  endfunction

  function automatic blk_t rand_blk();
    blk_t y;
    for (int k = 0; k < 64; k++) y[k*W +: W] = W'($urandom_range(32'hffff_ffff, 0));
    return y;
  endfunction

  function automatic int first_diff(input blk_t a, input blk_t b);
    for (int k = 0; k < 64; k++) if (a[k*W +: W] !== b[k*W +: W]) return k;
    return -1;
  endfunction

  // ---------------- driver for DUT A ----------------
  // Offers one block, waits for the result, optionally stalls the consumer for
  // 'hold' cycles (re-offering a block meanwhile), then completes the out handshake.
  task automatic drive_block_a(input blk_t data, input blk_t coeff, input int hold,
                               output blk_t got, output int lat, output int viol,
                               output int pass_cycles, output int unstable,
                               output bit timeout);
    int budget;
    got = '0; lat = 0; viol = 0; pass_cycles = 0; unstable = 0; timeout = 1'b0;
    @(negedge clk);
    in_valid_a = 1'b1; in_data_a = data; in_coeff_a = coeff;
    budget = 0;
    while (!in_ready_a && budget < 100) begin @(negedge clk); budget++; end
    if (!in_ready_a) begin timeout = 1'b1; in_valid_a = 1'b0; return; end
    @(negedge clk);  // acceptance edge t has passed
    in_valid_a = 1'b0; in_data_a = ~data; in_coeff_a = ~coeff;
    while (!out_valid_a && lat < 100) begin
      if (!busy_a || in_ready_a || dct_coeff_a !== coeff) viol++;
      if (dct_pass_a) pass_cycles++;
      @(negedge clk);
      lat++;
    end
    if (!out_valid_a) begin timeout = 1'b1; return; end
    got = out_data_a;
    for (int i = 0; i < hold; i++) begin
      in_valid_a = 1'b1;
      @(negedge clk);
      if (!out_valid_a || out_data_a !== got) unstable++;
      if (in_ready_a || !busy_a) viol++;
    end
    out_ready_a = 1'b1;
    @(negedge clk);
    out_ready_a = 1'b0;
    in_valid_a = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_vec++; if (st_a !== IDLE) begin n_err++; $display("FAIL reset_state_a: got %0d want %0d", st_a, IDLE); end
    n_vec++; if (in_ready_a !== 1'b1) begin n_err++; $display("FAIL reset_in_ready_a: got %b want 1", in_ready_a); end
    n_vec++; if (out_valid_a !== 1'b0) begin n_err++; $display("FAIL reset_out_valid_a: got %b want 0", out_valid_a); end
    n_vec++; if (busy_a !== 1'b0) begin n_err++; $display("FAIL reset_busy_a: got %b want 0", busy_a); end
    n_vec++; if (dct_pass_a !== 1'b0) begin n_err++; $display("FAIL reset_dct_pass_a: got %b want 0", dct_pass_a); end
    n_vec++; if (dct_data_in_a !== '0) begin n_err++; $display("FAIL reset_dct_data_in_a: word %0d nonzero", first_diff(dct_data_in_a, '0)); end
    n_vec++; if (dct_coeff_a !== '0) begin n_err++; $display("FAIL reset_dct_coeff_a: word %0d nonzero", first_diff(dct_coeff_a, '0)); end
    n_vec++; if (out_data_a !== '0) begin n_err++; $display("FAIL reset_out_data_a: word %0d nonzero", first_diff(out_data_a, '0)); end
    n_vec++; if (in_ready_b !== 1'b1 || out_valid_b !== 1'b0 || busy_b !== 1'b0 || dct_pass_b !== 1'b0)
      begin n_err++; $display("FAIL reset_flags_b: got rdy=%b vld=%b busy=%b pass=%b want 1 0 0 0", in_ready_b, out_valid_b, busy_b, dct_pass_b); end
    n_vec++; if (out_data_b !== '0) begin n_err++; $display("FAIL reset_out_data_b: word %0d nonzero", first_diff(out_data_b, '0)); end
    reset = 1'b0;
  endtask

  task automatic test_identity();
    blk_t got, exp; int lat, viol, pc, unst; bit to;
    mode = 0;
    exp_q.push_back(ramp());
    drive_block_a(ramp(), fill(32'h0000_0100), 0, got, lat, viol, pc, unst, to);
    exp = exp_q.pop_front();
    n_vec++; if (to !== 1'b0) begin n_err++; $display("FAIL identity_timeout: got %b want 0", to); end
    n_vec++; if (got !== exp) begin n_err++; $display("FAIL identity_data: word %0d got %0h want %0h", first_diff(got, exp), got[first_diff(got, exp)*W +: W], exp[first_diff(got, exp)*W +: W]); end
    // accept on edge t, out_valid seen after edge t+6 (seventh edge counting t)
    n_vec++; if (lat !== 6) begin n_err++; $display("FAIL identity_latency: got %0d want 6", lat); end
    n_vec++; if (viol !== 0) begin n_err++; $display("FAIL identity_busy_ready_coeff: got %0d bad cycles want 0", viol); end
    n_vec++; if (pc !== 3) begin n_err++; $display("FAIL identity_col_pass_cycles: got %0d want 3", pc); end
    n_vec++; if (in_ready_a !== 1'b1 || out_valid_a !== 1'b0 || busy_a !== 1'b0)
      begin n_err++; $display("FAIL identity_after_handshake: got rdy=%b vld=%b busy=%b want 1 0 0", in_ready_a, out_valid_a, busy_a); end
  endtask

  task automatic test_reverse();
    blk_t got, exp; int lat, viol, pc, unst; bit to;
    mode = 1;
    exp_q.push_back(rev_exp());
    drive_block_a(ramp(), ramp(), 0, got, lat, viol, pc, unst, to);
    exp = exp_q.pop_front();
    n_vec++; if (to !== 1'b0 || got !== exp) begin n_err++; $display("FAIL reverse_data: timeout %b word %0d got %0h want %0h", to, first_diff(got, exp), got[0 +: W], exp[0 +: W]); end
    n_vec++; if (lat !== 6) begin n_err++; $display("FAIL reverse_latency: got %0d want 6", lat); end
    n_vec++; if (viol !== 0) begin n_err++; $display("FAIL reverse_coeff_held: got %0d bad cycles want 0", viol); end
  endtask

  task automatic test_add_one();
    blk_t got, exp; int lat, viol, pc, unst; bit to;
    mode = 2;
    exp_q.push_back(fill(32'h12));
    drive_block_a(fill(32'h10), rand_blk(), 0, got, lat, viol, pc, unst, to);
    exp = exp_q.pop_front();
    n_vec++; if (to !== 1'b0 || got !== exp) begin n_err++; $display("FAIL add_one_data: timeout %b word %0d got %0h want 12", to, first_diff(got, exp), got[0 +: W]); end
    n_vec++; if (viol !== 0) begin n_err++; $display("FAIL add_one_in_ready_low: got %0d bad cycles want 0", viol); end
    n_vec++; if (in_ready_a !== 1'b1) begin n_err++; $display("FAIL add_one_ready_after: got %b want 1", in_ready_a); end
  endtask

  task automatic test_hold();
    blk_t got, exp, d; int lat, viol, pc, unst; bit to;
    mode = 0;
    d = rand_blk();
    exp_q.push_back(d);
    drive_block_a(d, rand_blk(), 20, got, lat, viol, pc, unst, to);
    exp = exp_q.pop_front();
    n_vec++; if (to !== 1'b0 || got !== exp) begin n_err++; $display("FAIL hold_data: timeout %b word %0d differs", to, first_diff(got, exp)); end
    n_vec++; if (unst !== 0) begin n_err++; $display("FAIL hold_stable: got %0d unstable cycles want 0", unst); end
    n_vec++; if (viol !== 0) begin n_err++; $display("FAIL hold_no_second_accept: got %0d bad cycles want 0", viol); end
    n_vec++; if (st_a !== IDLE) begin n_err++; $display("FAIL hold_idle_after: got %0d want %0d", st_a, IDLE); end
  endtask

  task automatic test_reset_mid_row();
    blk_t got, exp; int lat, viol, pc, unst, stale, budget; bit to;
    mode = 0;
    @(negedge clk);
    in_valid_a = 1'b1; in_data_a = fill(32'h55); in_coeff_a = fill(32'h66);
    budget = 0;
    while (!in_ready_a && budget < 100) begin @(negedge clk); budget++; end
    @(negedge clk);
    in_valid_a = 1'b0;
    n_vec++; if (st_a !== ROW) begin n_err++; $display("FAIL midrow_in_row: got %0d want %0d", st_a, ROW); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_vec++; if (st_a !== IDLE || in_ready_a !== 1'b1 || out_valid_a !== 1'b0 || busy_a !== 1'b0 || dct_pass_a !== 1'b0)
      begin n_err++; $display("FAIL midrow_flags: got st=%0d rdy=%b vld=%b busy=%b pass=%b want 0 1 0 0 0", st_a, in_ready_a, out_valid_a, busy_a, dct_pass_a); end
    n_vec++; if (dct_data_in_a !== '0 || dct_coeff_a !== '0 || out_data_a !== '0)
      begin n_err++; $display("FAIL midrow_regs_cleared: got word %0d/%0d/%0d nonzero want -1", first_diff(dct_data_in_a, '0), first_diff(dct_coeff_a, '0), first_diff(out_data_a, '0)); end
    stale = 0;
    repeat (12) begin @(negedge clk); if (out_valid_a || busy_a) stale++; end
    n_vec++; if (stale !== 0) begin n_err++; $display("FAIL midrow_no_stale: got %0d cycles want 0", stale); end
    exp_q.push_back(ramp());
    drive_block_a(ramp(), fill(32'h7), 0, got, lat, viol, pc, unst, to);
    exp = exp_q.pop_front();
    n_vec++; if (to !== 1'b0 || got !== exp || lat !== 6) begin n_err++; $display("FAIL midrow_next_block: timeout %b word %0d lat %0d want 6", to, first_diff(got, exp), lat); end
  endtask

  task automatic test_lat0_back_to_back();
    int acc, seen, bad_data;
    int times[4];
    mode = 0;
    seen = 0; bad_data = 0;
    @(negedge clk);
    in_valid_b = 1'b1; out_ready_b = 1'b1; in_data_b = ramp(); in_coeff_b = fill(32'h3);
    n_vec++; if (in_ready_b !== 1'b1) begin n_err++; $display("FAIL lat0_ready: got %b want 1", in_ready_b); end
    @(negedge clk);
    acc = cyc;
    exp_q.push_back(ramp());
    for (int i = 0; i < 16; i++) begin
      if (out_valid_b) begin
        if (seen < 4) times[seen] = cyc - acc;
        seen++;
        if (out_data_b !== exp_q[0]) bad_data++;
      end
      @(negedge clk);
    end
    in_valid_b = 1'b0; out_ready_b = 1'b0;
    void'(exp_q.pop_front());
    n_vec++; if (seen !== 4) begin n_err++; $display("FAIL lat0_count: got %0d results want 4", seen); end
    n_vec++; if (bad_data !== 0) begin n_err++; $display("FAIL lat0_data: got %0d bad results want 0", bad_data); end
    n_vec++; if (seen >= 1 && times[0] !== 2) begin n_err++; $display("FAIL lat0_latency: got %0d want 2", times[0]); end
    for (int k = 1; k < 4; k++) begin
      n_vec++; if (seen > k && times[k] - times[k-1] !== 4) begin n_err++; $display("FAIL lat0_period%0d: got %0d want 4", k, times[k] - times[k-1]); end
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    exp_q_unused = 1'b0;
    reset = 1'b1;
    in_valid_a = 1'b0; out_ready_a = 1'b0; in_data_a = '0; in_coeff_a = '0;
    in_valid_b = 1'b0; out_ready_b = 1'b0; in_data_b = '0; in_coeff_b = '0;
    test_reset();
    test_identity();
    test_reverse();
    test_add_one();
    test_hold();
    test_reset_mid_row();
    test_lat0_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
